// File: rtl/serial_chunk_adder_seq.sv
// Sequential WIDTH-bit adder that time-shares one CHUNK-bit ripple-carry adder, LS chunk first.
// Optional signed-overflow output `ovf` is built only when SEQ_ADDER_OVF_EN is defined.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module N_bit_RippleCarryAdder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;

  assign c[0] = cin;
  full_adder fa [N-1:0] (
    .a    (a),
    .b    (b),
    .cin  (c[N-1:0]),
    .s    (sum),
    .cout (c[N:1])
  );
  assign cout = c[N];
endmodule

module serial_chunk_adder_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int K  = WIDTH / CHUNK;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [K-1:0][CHUNK-1:0]   a_q, b_q, sum_q;
  logic [IW-1:0]             idx;
  logic                      carry_q, cout_q;
  logic [CHUNK-1:0]          a_ch, b_ch, add_s;
  logic                      add_co;
  logic                      last;

  // Chunk select by compare rather than variable part-select keeps K=1 legal.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int k = 0; k < K; k++) begin
      if (idx == IW'(k)) begin
        a_ch = a_q[k];
        b_ch = b_q[k];
      end
    end
  end

  assign last = (idx == IW'(K - 1));

  N_bit_RippleCarryAdder #(.N(CHUNK)) u_rca (
    .a    (a_ch),
    .b    (b_ch),
    .cin  (carry_q),
    .sum  (add_s),
    .cout (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx     <= '0;
    end else if (state_q == RUN) begin
      for (int k = 0; k < K; k++)
        if (idx == IW'(k)) sum_q[k] <= add_s;
      carry_q <= add_co;
      if (last) begin
        cout_q <= add_co;
        idx    <= '0;
      end else begin
        idx    <= idx + 1'b1;
      end
    end
  end

`ifdef SEQ_ADDER_OVF_EN
  logic ovf_q;

  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (state_q == RUN && last)
      ovf_q <= a_q[K-1][CHUNK-1] ^ b_q[K-1][CHUNK-1] ^ add_s[CHUNK-1] ^ add_co;
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: doc/serial_chunk_adder_seq.md
# serial_chunk_adder_seq

Multi-cycle sequencer that adds two WIDTH-bit operands by time-sharing one CHUNK-bit ripple-carry adder (an instance of the codebase's `N_bit_RippleCarryAdder` with N = CHUNK). It processes one chunk per clock, least-significant chunk first, and registers the carry between chunks. It sits between a valid/ready producer and consumer. It trades latency for area wherever a full-width adder is too large.

## Interface
- WIDTH, 32: operand and sum width; must be an integer multiple of CHUNK.
- CHUNK, 8: width of the shared ripple-carry adder; K = WIDTH/CHUNK chunks per operation.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and cin are valid.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- a  in  WIDTH  operand A; sampled on the accept edge.
- b  in  WIDTH  operand B; sampled on the accept edge.
- cin  in  1  carry-in to chunk 0; sampled on the accept edge.
- out_valid  out  1  sum and cout are valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  registered result.
- cout  out  1  carry out of the MSB.
- busy  out  1  high in RUN or DONE.
- ovf  out  1  signed overflow; present only with SEQ_ADDER_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready: latch a and b, set carry_q=cin and idx=0, go to RUN.
- RUN, once per edge:
  - Adder inputs are a_q[idx*CHUNK +: CHUNK], b_q[idx*CHUNK +: CHUNK] and carry_q.
  - Write the adder result into sum[idx*CHUNK +: CHUNK], and write the adder carry-out into carry_q.
  - Increment idx.
  - On the edge that processes idx=K-1: go to DONE and load cout with that chunk's carry-out.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are held stable until the edge where out_ready=1; that edge moves the FSM to IDLE.
- Handshakes:
  - in_valid while busy is ignored. No queueing; the producer must hold its request.
  - out_valid, once raised, is not dropped until the handshake completes.
- Arithmetic:
  - Unsigned modulo 2^WIDTH plus carry: {cout,sum} = a + b + cin.
  - idx is a ceil(log2(K))-bit counter (minimum 1 bit); it never wraps in use.
- Chunk results are written in place. Upper chunks of sum hold stale data during RUN; sum is defined only while out_valid=1.
- Reset:
  - rst has priority in every state; a mid-RUN or mid-DONE reset aborts the operation with no output.
  - After the reset edge: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, idx=0, carry_q=0.
- K=1 (CHUNK=WIDTH) is legal: RUN lasts exactly one edge.

## Timing
- Accept edge E0. Chunks are processed on edges E1..EK; out_valid is high after EK. Latency from accept to out_valid is K cycles (4 at 32/8).
- With out_ready already high, DONE lasts one cycle and IDLE follows after E(K+1).
- The earliest next accept is E(K+2), giving a minimum initiation interval of K+2 cycles.
- All outputs are registered or decoded from the registered state only. No combinational path runs from in_valid/out_ready to any output.
- The adder's critical path is CHUNK full-adder stages, independent of WIDTH.

## Configuration
- SEQ_ADDER_OVF_EN defined:
  - Port ovf exists.
  - On the final RUN edge, ovf is loaded with (carry into the MSB) XOR (carry out of the MSB).
  - The carry into the MSB equals a_q[WIDTH-1]^b_q[WIDTH-1]^sum_bit[WIDTH-1].
  - ovf is held with sum and cleared by rst.
- SEQ_ADDER_OVF_EN undefined: port ovf and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=32, CHUNK=8; a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 4 cycles: out_valid=1, sum=0x00000000, cout=1. The carry must ripple across all chunk boundaries.
- a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0; in_ready=0 from E1 until the output handshake.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid; pulse in_valid with new operands -> sum and cout unchanged, in_ready=0, the request is ignored; on out_ready=1, IDLE follows after one edge.
- rst asserted for one edge while idx=2 in RUN -> next cycle: in_ready=1, out_valid=0, sum=0. A new operation a=5, b=7 then yields sum=12.
- SEQ_ADDER_OVF_EN defined: a=0x7FFFFFFF, b=0x00000001 -> ovf=1, cout=0. a=0xFFFFFFFF, b=0x00000001 -> ovf=0, cout=1.
- CHUNK=32 (K=1) and random back-to-back traffic against a reference model -> latency 1, initiation interval 3, all sums match.
